// File: rtl/pipeline_debug_pkg.sv
// Shared constants and state encoding for the host debug loader.
// Command bytes arrive from the UART; reply bytes go back to the host.
package pipeline_debug_pkg;

    localparam int NBITS = 32;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_CNT,
        ST_LD_DATA,
        ST_WR,
        ST_RUN,
        ST_STEP,
        ST_SEND_PC,
        ST_SEND_ACK
    } state_t;

endpackage

// File: rtl/pipeline_debug_loader_if.sv
// Host byte streams, instruction-memory write port and pipeline control.
// The slave modport is the loader; the master modport is its environment.
interface pipeline_debug_loader_if;
    import pipeline_debug_pkg::*;

    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic [7:0]       o_tx_data;
    logic             o_tx_valid;
    logic             i_tx_ready;
    logic             o_inst_mem_wr_en;
    logic [NBITS-1:0] o_inst_mem_addr;
    logic [NBITS-1:0] o_inst_mem_data;
    logic             o_cpu_en;
    logic [NBITS-1:0] i_pc;
    logic             i_halt;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_pc, i_halt,
        output o_tx_data, o_tx_valid, o_inst_mem_wr_en,
        output o_inst_mem_addr, o_inst_mem_data, o_cpu_en
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_ready, i_pc, i_halt,
        input  o_tx_data, o_tx_valid, o_inst_mem_wr_en,
        input  o_inst_mem_addr, o_inst_mem_data, o_cpu_en
    );

endinterface

// File: rtl/debug_tx_serializer.sv
// Sends up to four bytes MSB first over a valid/ready handshake.
// done is high on the cycle the final byte is accepted.
module debug_tx_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] sr;
    logic [2:0]  cnt;

    assign tx_data = sr[31:24];
    assign done    = tx_valid & tx_ready & (cnt == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            sr       <= load_data;
            cnt      <= load_cnt;
            tx_valid <= (load_cnt != 3'd0);
        end else if (tx_valid && tx_ready) begin
            sr       <= {sr[23:0], 8'h00};
            cnt      <= cnt - 3'd1;
            tx_valid <= (cnt != 3'd1);
        end
    end

endmodule

// File: rtl/pipeline_debug_loader.sv
// Host-side debug controller: loads instruction memory, runs or steps
// the pipeline through a clock enable, and reports the PC afterwards.
module pipeline_debug_loader
    import pipeline_debug_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    pipeline_debug_loader_if.slave  bus
);

    state_t           state;
    logic [7:0]       word_cnt;
    logic [7:0]       word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic [7:0]       rsp;
    logic             tx_started;
    logic             cpu_en;
    logic             wr_en;
    logic [NBITS-1:0] wr_addr;
    logic [NBITS-1:0] wr_data;

    logic             sending;
    logic             ser_load;
    logic [31:0]      ser_data;
    logic [2:0]       ser_cnt;
    logic             ser_done;

    assign sending  = (state == ST_SEND_PC) || (state == ST_SEND_ACK);
    assign ser_load = sending && !tx_started;
    // PC is sampled in the first SEND_PC cycle, after a step has taken effect
    assign ser_data = (state == ST_SEND_PC) ? bus.i_pc : {rsp, 24'h0};
    assign ser_cnt  = (state == ST_SEND_PC) ? 3'd4 : 3'd1;

    assign bus.o_cpu_en         = cpu_en;
    assign bus.o_inst_mem_wr_en = wr_en;
    assign bus.o_inst_mem_addr  = wr_addr;
    assign bus.o_inst_mem_data  = wr_data;

    debug_tx_serializer u_ser (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .load      (ser_load),
        .load_data (ser_data),
        .load_cnt  (ser_cnt),
        .tx_data   (bus.o_tx_data),
        .tx_valid  (bus.o_tx_valid),
        .tx_ready  (bus.i_tx_ready),
        .done      (ser_done)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            rsp        <= '0;
            tx_started <= 1'b0;
            cpu_en     <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_rx_valid) begin
                        unique case (1'b1)
                            (bus.i_rx_data == CMD_LOAD): state <= ST_LD_CNT;
                            (bus.i_rx_data == CMD_RUN): begin
                                if (bus.i_halt) begin
                                    state <= ST_SEND_PC;
                                end else begin
                                    cpu_en <= 1'b1;
                                    state  <= ST_RUN;
                                end
                            end
                            (bus.i_rx_data == CMD_STEP): begin
                                cpu_en <= 1'b1;
                                state  <= ST_STEP;
                            end
                            default: begin
                                rsp   <= RSP_ERR;
                                state <= ST_SEND_ACK;
                            end
                        endcase
                    end
                end
                ST_LD_CNT: begin
                    if (bus.i_rx_valid) begin
                        word_cnt <= bus.i_rx_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                        state    <= ST_LD_DATA;
                    end
                end
                ST_LD_DATA: begin
                    if (bus.i_rx_valid) begin
                        if (byte_idx == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {{(NBITS-10){1'b0}}, word_idx, 2'b00};
                            wr_data  <= {word_buf, bus.i_rx_data};
                            byte_idx <= '0;
                            state    <= ST_WR;
                        end else begin
                            word_buf <= {word_buf[15:0], bus.i_rx_data};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                ST_WR: begin
                    word_idx <= word_idx + 8'd1;
                    // count byte 0 means 256 words; the 8-bit wrap handles it
                    if (word_idx == word_cnt - 8'd1) begin
                        rsp   <= RSP_ACK;
                        state <= ST_SEND_ACK;
                    end else begin
                        state <= ST_LD_DATA;
                    end
                end
                ST_RUN: begin
                    if (bus.i_halt) begin
                        cpu_en <= 1'b0;
                        state  <= ST_SEND_PC;
                    end
                end
                ST_STEP: begin
                    cpu_en <= 1'b0;
                    state  <= ST_SEND_PC;
                end
                ST_SEND_PC, ST_SEND_ACK: begin
                    if (ser_load) begin
                        tx_started <= 1'b1;
                    end else if (ser_done) begin
                        tx_started <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_debug_loader.sv
// Scoreboard bench for pipeline_debug_loader: directed host sessions,
// expected tx bytes, memory writes and cpu_en run lengths queued up front.
module tb_pipeline_debug_loader;
    import pipeline_debug_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_debug_loader_if bus ();

    pipeline_debug_loader dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];
    int          exp_cpu[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic extra(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got %0h want nothing", name, act);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic push_pc(input logic [31:0] pc);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(pc[i*8 +: 8]);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 ||
                exp_cpu.size() != 0 || bus.o_cpu_en) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) extra("timeout", 64'(exp_tx.size()));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_data"}, 64'(bus.o_tx_data), 64'h0);
        check({tag, "_tx_valid"}, 64'(bus.o_tx_valid), 64'h0);
        check({tag, "_wr_en"}, 64'(bus.o_inst_mem_wr_en), 64'h0);
        check({tag, "_addr"}, 64'(bus.o_inst_mem_addr), 64'h0);
        check({tag, "_data"}, 64'(bus.o_inst_mem_data), 64'h0);
        check({tag, "_cpu_en"}, 64'(bus.o_cpu_en), 64'h0);
    endtask

    // Monitor: samples just after each falling edge
    initial begin
        int run = 0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                run = 0;
            end else begin
                if (bus.o_tx_valid && bus.i_tx_ready) begin
                    if (exp_tx.size() == 0) extra("tx_byte", 64'(bus.o_tx_data));
                    else check("tx_byte", 64'(bus.o_tx_data), 64'(exp_tx.pop_front()));
                end
                if (bus.o_inst_mem_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        extra("wr_event", 64'(bus.o_inst_mem_addr));
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 64'(bus.o_inst_mem_addr), {32'h0, e[63:32]});
                        check("wr_data", 64'(bus.o_inst_mem_data), {32'h0, e[31:0]});
                    end
                end
                if (bus.o_cpu_en) begin
                    run++;
                end else if (run > 0) begin
                    if (exp_cpu.size() == 0) extra("cpu_en_run", 64'(run));
                    else check("cpu_en_run", 64'(run), 64'(exp_cpu.pop_front()));
                    run = 0;
                end
            end
        end
    end

    initial begin
        int t;
        logic [7:0] held;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b1;
        bus.i_pc       = 32'h0;
        bus.i_halt     = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word load
        exp_wr.push_back({32'h0, 32'h00000001});
        exp_wr.push_back({32'h4, 32'hAABBCCDD});
        exp_tx.push_back(RSP_ACK);
        send(CMD_LOAD);
        send(8'h02);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        wait_done();

        // Single step with latency checks
        bus.i_pc = 32'h00000010;
        exp_cpu.push_back(1);
        push_pc(32'h00000010);
        send(CMD_STEP);
        check("step_cpu_en_c1", 64'(bus.o_cpu_en), 64'h1);
        @(negedge clk);
        check("step_tx_valid_c2", 64'(bus.o_tx_valid), 64'h0);
        @(negedge clk);
        check("step_tx_valid_c3", 64'(bus.o_tx_valid), 64'h1);
        wait_done();

        // Run until halt 20 cycles after enable
        bus.i_pc = 32'h0000003C;
        exp_cpu.push_back(21);
        push_pc(32'h0000003C);
        send(CMD_RUN);
        repeat (20) @(negedge clk);
        bus.i_halt = 1'b1;
        wait_done();

        // Run with halt already high: no enable at all
        bus.i_pc = 32'hDEADBEEF;
        push_pc(32'hDEADBEEF);
        send(CMD_RUN);
        wait_done();
        bus.i_halt = 1'b0;

        // Unknown command, then a step
        exp_tx.push_back(RSP_ERR);
        send(8'h58);
        wait_done();
        bus.i_pc = 32'h00000010;
        exp_cpu.push_back(1);
        push_pc(32'h00000010);
        send(CMD_STEP);
        wait_done();

        // Back-pressure on the first PC byte
        bus.i_pc = 32'h12345678;
        bus.i_tx_ready = 1'b0;
        exp_cpu.push_back(1);
        push_pc(32'h12345678);
        send(CMD_STEP);
        t = 0;
        while (!bus.o_tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        held = bus.o_tx_data;
        check("bp_first_byte", 64'(held), 64'h12);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 64'(bus.o_tx_valid), 64'h1);
            check("bp_data_stable", 64'(bus.o_tx_data), 64'h12);
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        bus.i_tx_ready = 1'b1;
        wait_done();

        // Reset while running drops cpu_en at once
        bus.i_pc = 32'h0;
        send(CMD_RUN);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("run_rst_cpu_en", 64'(bus.o_cpu_en), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-load, then a fresh load starts at index 0
        send(CMD_LOAD);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        rst = 1'b0;
        #1;
        check_zero("midload");
        @(negedge clk);
        rst = 1'b1;
        exp_wr.push_back({32'h0, 32'hCAFEF00D});
        exp_tx.push_back(RSP_ACK);
        send(CMD_LOAD);
        send(8'h01);
        send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
        wait_done();

        check("queues_drained", 64'(exp_tx.size() + exp_wr.size() + exp_cpu.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
